mem_port_arbiter: RTL and testbench

//   Shares one single-port unified memory between the IF stage (instruction fetch) and the
//   MEM stage (load/store) of the 5-stage pipeline. Fixed-priority arbiter plus a

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_acc_lat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, requester IDs and
// the latency counter sizing helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } reqId_t;

  // Counter must hold MEM_LAT-1; sized as $clog2(MEM_LAT+1) so MEM_LAT=1 still gets one bit.
  function automatic int cntWidth(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the port arbiter. slave is the arbiter view,
// master is the pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter_acc_lat_counter.sv
// Access latency counter: loaded with MEM_LAT-1 on a grant, counts down while busy,
// zero marks the last memory cycle of the access.
module acc_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CNT_W = cntWidth(MEM_LAT);

  logic [CNT_W-1:0] cntReg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cntReg <= '0;
    end else if (load) begin
      cntReg <= CNT_W'(MEM_LAT - 1);
    end else if (dec && (cntReg != '0)) begin
      cntReg <= cntReg - CNT_W'(1);
    end
  end

  assign zero = (cntReg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory between fetch and data access;
// data wins because the MEM-stage instruction is older.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  arbState_t         stateReg;
  logic              ifReadyReg;
  logic              dmReadyReg;
  logic              memEnReg;
  logic              memWeReg;
  logic              storeReg;
  logic [ADDR_W-1:0] memAddrReg;
  logic [DATA_W-1:0] memWdataReg;
  logic [DATA_W-1:0] ifRdataReg;
  logic [DATA_W-1:0] dmRdataReg;

  logic   wantD;
  logic   wantI;
  logic   grant;
  logic   cntZero;
  reqId_t winner;

  // A requester whose ready is high this cycle has been consumed and may not win again yet.
  assign wantD  = bus.dm_req & ~dmReadyReg;
  assign wantI  = bus.if_req & ~ifReadyReg;
  assign grant  = (stateReg == IDLE) & (wantD | wantI);
  assign winner = wantD ? REQ_D : REQ_I;

  acc_lat_counter #(.MEM_LAT(MEM_LAT)) latCnt (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .dec  (stateReg != IDLE),
    .zero (cntZero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateReg    <= IDLE;
      ifReadyReg  <= 1'b0;
      dmReadyReg  <= 1'b0;
      memEnReg    <= 1'b0;
      memWeReg    <= 1'b0;
      storeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      ifRdataReg  <= '0;
      dmRdataReg  <= '0;
    end else begin
      ifReadyReg <= 1'b0;
      dmReadyReg <= 1'b0;
      memWeReg   <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (grant) begin
            memEnReg <= 1'b1;
            if (winner == REQ_D) begin
              stateReg    <= BUSY_D;
              memAddrReg  <= bus.dm_addr;
              memWdataReg <= bus.dm_wdata;
              memWeReg    <= bus.dm_we;
              storeReg    <= bus.dm_we;
            end else begin
              stateReg   <= BUSY_I;
              memAddrReg <= bus.if_addr;
              storeReg   <= 1'b0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (cntZero) begin
            stateReg <= IDLE;
            memEnReg <= 1'b0;
            if (stateReg == BUSY_I) begin
              ifReadyReg <= 1'b1;
              ifRdataReg <= bus.mem_rdata;
            end else begin
              dmReadyReg <= 1'b1;
              // Stores complete without disturbing the last load result.
              if (!storeReg) begin
                dmRdataReg <= bus.mem_rdata;
              end
            end
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.if_ready  = ifReadyReg;
  assign bus.if_rdata  = ifRdataReg;
  assign bus.dm_ready  = dmReadyReg;
  assign bus.dm_rdata  = dmRdataReg;
  assign bus.mem_en    = memEnReg;
  assign bus.mem_we    = memWeReg;
  assign bus.mem_addr  = memAddrReg;
  assign bus.mem_wdata = memWdataReg;
  assign bus.stall_if  = rst & bus.if_req & ~ifReadyReg;
  assign bus.stall_mem = rst & bus.dm_req & ~dmReadyReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on MEM_LAT=2 and MEM_LAT=1 builds, then
// random traffic checked against a cycle-arithmetic transaction model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic memLoad = 1'b1;
  int   checks  = 0;
  int   fails   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) busA ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) busB ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  function automatic logic [DW-1:0] memPattern(input int i);
    if (i == 5)  return 32'h2008000A;
    if (i == 16) return 32'hDEADBEEF;
    return 32'h1000_0000 + DW'(i) * 32'h0001_0003;
  endfunction

  // Single-port memories behind each arbiter: asynchronous read, write on the clock edge.
  logic [DW-1:0] memA [DEPTH];
  logic [DW-1:0] memB [DEPTH];

  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < DEPTH; i++) begin
        memA[i] <= memPattern(i);
        memB[i] <= memPattern(i);
      end
    end else begin
      if (busA.mem_en && busA.mem_we) memA[busA.mem_addr] <= busA.mem_wdata;
      if (busB.mem_en && busB.mem_we) memB[busB.mem_addr] <= busB.mem_wdata;
    end
  end

  assign busA.mem_rdata = memA[busA.mem_addr];
  assign busB.mem_rdata = memB[busB.mem_addr];

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    busA.if_req = 1'b0; busA.if_addr = '0; busA.dm_req = 1'b0;
    busA.dm_we = 1'b0; busA.dm_addr = '0; busA.dm_wdata = '0;
    busB.if_req = 1'b0; busB.if_addr = '0; busB.dm_req = 1'b0;
    busB.dm_we = 1'b0; busB.dm_addr = '0; busB.dm_wdata = '0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    idleInputs();
    rst = 1'b0;
    memLoad = 1'b1;
    busA.if_req = 1'b1;
    busA.dm_req = 1'b1;
    repeat (3) nextCycle();
    @(negedge clk);
    got = {busA.if_ready, busA.dm_ready, busA.mem_en, busA.mem_we, busA.stall_if, busA.stall_mem};
    checks++;
    if (got !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl_A: got %b, expected 000000", got);
    end
    checks++;
    if ({busA.if_rdata, busA.dm_rdata} !== 64'd0) begin
      fails++;
      $display("FAIL reset_rdata_A: got %h %h, expected 0 0", busA.if_rdata, busA.dm_rdata);
    end
    got = {busB.if_ready, busB.dm_ready, busB.mem_en, busB.mem_we, busB.stall_if, busB.stall_mem};
    checks++;
    if (got !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl_B: got %b, expected 000000", got);
    end
    nextCycle();
    idleInputs();
    rst = 1'b1;
    memLoad = 1'b0;
  endtask

  task automatic test_fetch();
    logic [3:0] exp;
    for (int c = 0; c <= 4; c++) begin
      nextCycle();
      if (c == 0) begin busA.if_req = 1'b1; busA.if_addr = 7'h05; end
      if (c == 4) busA.if_req = 1'b0;
      @(negedge clk);
      exp = {c == 3, c == 1 || c == 2, 1'b0, c < 3};
      checks++;
      if ({busA.if_ready, busA.mem_en, busA.mem_we, busA.stall_if} !== exp) begin
        fails++;
        $display("FAIL fetch_ctrl c%0d: got %b, expected %b", c,
                 {busA.if_ready, busA.mem_en, busA.mem_we, busA.stall_if}, exp);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (busA.mem_addr !== 7'h05) begin
          fails++;
          $display("FAIL fetch_addr c%0d: got %h, expected 05", c, busA.mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (busA.if_rdata !== 32'h2008000A) begin
          fails++;
          $display("FAIL fetch_rdata: got %h, expected 2008000a", busA.if_rdata);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp;
    logic [5:0] got;
    for (int c = 0; c <= 7; c++) begin
      nextCycle();
      if (c == 0) begin
        busA.if_req = 1'b1; busA.if_addr = 7'h05;
        busA.dm_req = 1'b1; busA.dm_we = 1'b0; busA.dm_addr = 7'h10;
      end
      if (c == 4) busA.dm_req = 1'b0;
      if (c == 7) busA.if_req = 1'b0;
      @(negedge clk);
      got = {busA.if_ready, busA.dm_ready, busA.mem_en, busA.mem_we, busA.stall_if, busA.stall_mem};
      exp = {c == 6, c == 3, c == 1 || c == 2 || c == 4 || c == 5, 1'b0, c <= 5, c <= 2};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL simul_ctrl c%0d: got %b, expected %b", c, got, exp);
      end
      if (c == 1 || c == 2 || c == 4 || c == 5) begin
        checks++;
        if (busA.mem_addr !== ((c < 3) ? 7'h10 : 7'h05)) begin
          fails++;
          $display("FAIL simul_addr c%0d: got %h", c, busA.mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (busA.dm_rdata !== 32'hDEADBEEF) begin
          fails++;
          $display("FAIL simul_dm_rdata: got %h, expected deadbeef", busA.dm_rdata);
        end
      end
      if (c == 6) begin
        checks++;
        if (busA.if_rdata !== 32'h2008000A) begin
          fails++;
          $display("FAIL simul_if_rdata: got %h, expected 2008000a", busA.if_rdata);
        end
      end
    end
  endtask

  task automatic test_store_load();
    logic [3:0] exp;
    logic [3:0] got;
    for (int c = 0; c <= 8; c++) begin
      nextCycle();
      if (c == 0) begin
        busA.dm_req = 1'b1; busA.dm_we = 1'b1; busA.dm_addr = 7'h03; busA.dm_wdata = 32'h12345678;
      end
      if (c == 4) begin busA.dm_we = 1'b0; busA.dm_wdata = '0; end
      if (c == 8) busA.dm_req = 1'b0;
      @(negedge clk);
      got = {busA.dm_ready, busA.mem_en, busA.mem_we, busA.stall_mem};
      exp = {c == 3 || c == 7, c == 1 || c == 2 || c == 5 || c == 6, c == 1,
             c != 3 && c != 7 && c != 8};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL store_ctrl c%0d: got %b, expected %b", c, got, exp);
      end
      if (c == 1) begin
        checks++;
        if ({busA.mem_addr, busA.mem_wdata} !== {7'h03, 32'h12345678}) begin
          fails++;
          $display("FAIL store_bus: got %h/%h, expected 03/12345678", busA.mem_addr, busA.mem_wdata);
        end
      end
      if (c == 3 || c == 7) begin
        checks++;
        if (busA.dm_rdata !== ((c == 3) ? 32'hDEADBEEF : 32'h12345678)) begin
          fails++;
          $display("FAIL store_rdata c%0d: got %h", c, busA.dm_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    logic [2:0] got;
    for (int c = 0; c <= 7; c++) begin
      nextCycle();
      if (c == 0) begin busA.if_req = 1'b1; busA.if_addr = 7'h09; end
      if (c == 2) rst = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 7) busA.if_req = 1'b0;
      @(negedge clk);
      got = {busA.if_ready, busA.mem_en, busA.stall_if};
      exp = {c == 6, c == 1 || c == 2 || c == 4 || c == 5, c != 2 && c < 6};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL rstmid_ctrl c%0d: got %b, expected %b", c, got, exp);
      end
      if (c == 3 || c == 6) begin
        checks++;
        if (busA.if_rdata !== ((c == 3) ? 32'd0 : memPattern(9))) begin
          fails++;
          $display("FAIL rstmid_rdata c%0d: got %h", c, busA.if_rdata);
        end
      end
    end
  endtask

  task automatic test_held_req();
    logic [2:0] exp;
    logic [2:0] got;
    int pulses = 0;
    for (int c = 0; c <= 8; c++) begin
      nextCycle();
      if (c == 0) begin busA.if_req = 1'b1; busA.if_addr = 7'h05; end
      if (c == 3) busA.if_addr = 7'h06;
      if (c == 8) busA.if_req = 1'b0;
      @(negedge clk);
      if (busA.if_ready === 1'b1) pulses++;
      got = {busA.if_ready, busA.mem_en, busA.stall_if};
      exp = {c == 3 || c == 7, c == 1 || c == 2 || c == 5 || c == 6, c != 3 && c < 7};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL held_ctrl c%0d: got %b, expected %b", c, got, exp);
      end
      if (c == 3 || c == 7) begin
        checks++;
        if (busA.if_rdata !== ((c == 3) ? 32'h2008000A : memPattern(6))) begin
          fails++;
          $display("FAIL held_rdata c%0d: got %h", c, busA.if_rdata);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL held_pulses: got %0d, expected 2", pulses);
    end
  endtask

  task automatic test_lat1();
    logic [4:0] exp;
    logic [4:0] got;
    for (int c = 0; c <= 3; c++) begin
      nextCycle();
      if (c == 0) begin busB.if_req = 1'b1; busB.if_addr = 7'h05; end
      if (c == 3) busB.if_req = 1'b0;
      @(negedge clk);
      got = {busB.if_ready, 1'b0, busB.mem_en, busB.stall_if, 1'b0};
      exp = {c == 2, 1'b0, c == 1, c < 2, 1'b0};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL lat1_fetch c%0d: got %b, expected %b", c, got, exp);
      end
      if (c == 2) begin
        checks++;
        if (busB.if_rdata !== 32'h2008000A) begin
          fails++;
          $display("FAIL lat1_rdata: got %h, expected 2008000a", busB.if_rdata);
        end
      end
    end
    // Both requesters busy: completions alternate data/fetch every two cycles.
    for (int c = 0; c <= 9; c++) begin
      nextCycle();
      if (c == 0) begin
        busB.if_req = 1'b1; busB.if_addr = 7'h05;
        busB.dm_req = 1'b1; busB.dm_we = 1'b0; busB.dm_addr = 7'h10;
      end
      if (c == 7) busB.dm_req = 1'b0;
      if (c == 9) busB.if_req = 1'b0;
      @(negedge clk);
      got = {busB.if_ready, busB.dm_ready, busB.mem_en, busB.stall_if, busB.stall_mem};
      exp = {c == 4 || c == 8, c == 2 || c == 6, c == 1 || c == 3 || c == 5 || c == 7,
             c != 4 && c < 8, c != 2 && c < 6};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL lat1_b2b c%0d: got %b, expected %b", c, got, exp);
      end
      if (c == 1 || c == 3 || c == 5 || c == 7) begin
        checks++;
        if (busB.mem_addr !== ((c == 1 || c == 5) ? 7'h10 : 7'h05)) begin
          fails++;
          $display("FAIL lat1_addr c%0d: got %h", c, busB.mem_addr);
        end
      end
      if (c == 2 || c == 6) begin
        checks++;
        if (busB.dm_rdata !== 32'hDEADBEEF) begin
          fails++;
          $display("FAIL lat1_dm_rdata c%0d: got %h, expected deadbeef", c, busB.dm_rdata);
        end
      end
    end
  endtask

  task automatic test_random(input int nCycles);
    logic [DW-1:0] refMem [DEPTH];
    logic [DW-1:0] expIf, expDm, result, ownWdata;
    logic [AW-1:0] ownAddr;
    logic [5:0]    expCtrl, gotCtrl;
    reqId_t        owner;
    bit            ifOut, dmOut, busy, ownStore, ifRdy, dmRdy, en, we;
    int            grantAt;
    busy = 1'b0; ifOut = 1'b0; dmOut = 1'b0; ownStore = 1'b0;
    expIf = '0; expDm = '0; result = '0; ownWdata = '0; ownAddr = '0;
    owner = REQ_I; grantAt = 0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = memPattern(i);
    nextCycle();
    idleInputs();
    rst = 1'b0;
    memLoad = 1'b1;
    for (int k = 0; k < nCycles; k++) begin
      nextCycle();
      if (k == 0) begin rst = 1'b1; memLoad = 1'b0; end
      if (!ifOut) ifOut = ($urandom_range(0, 2) == 0);
      if (!dmOut) dmOut = ($urandom_range(0, 3) == 0);
      busA.if_req   = ifOut;
      busA.if_addr  = AW'($urandom);
      busA.dm_req   = dmOut;
      busA.dm_we    = 1'($urandom);
      busA.dm_addr  = AW'($urandom_range(0, 15));
      busA.dm_wdata = $urandom;
      // An access granted in cycle g owns the memory in g+1..g+LAT and completes in g+LAT+1.
      ifRdy = busy && owner == REQ_I && k == grantAt + LAT + 1;
      dmRdy = busy && owner == REQ_D && k == grantAt + LAT + 1;
      en    = busy && k > grantAt && k <= grantAt + LAT;
      we    = en && ownStore && k == grantAt + 1;
      if (ifRdy) expIf = result;
      if (dmRdy && !ownStore) expDm = result;
      expCtrl = {ifRdy, dmRdy, en, we, ifOut && !ifRdy, dmOut && !dmRdy};
      @(negedge clk);
      gotCtrl = {busA.if_ready, busA.dm_ready, busA.mem_en, busA.mem_we, busA.stall_if, busA.stall_mem};
      checks++;
      if (gotCtrl !== expCtrl) begin
        fails++;
        $display("FAIL rand_ctrl cycle %0d: got %b, expected %b", k, gotCtrl, expCtrl);
      end
      if (en) begin
        checks++;
        if (busA.mem_addr !== ownAddr) begin
          fails++;
          $display("FAIL rand_addr cycle %0d: got %h, expected %h", k, busA.mem_addr, ownAddr);
        end
      end
      if (we) begin
        checks++;
        if (busA.mem_wdata !== ownWdata) begin
          fails++;
          $display("FAIL rand_wdata cycle %0d: got %h, expected %h", k, busA.mem_wdata, ownWdata);
        end
      end
      checks++;
      if ({busA.if_rdata, busA.dm_rdata} !== {expIf, expDm}) begin
        fails++;
        $display("FAIL rand_rdata cycle %0d: got %h/%h, expected %h/%h",
                 k, busA.if_rdata, busA.dm_rdata, expIf, expDm);
      end
      if (ifRdy || dmRdy) busy = 1'b0;
      if (!busy && ((dmOut && !dmRdy) || (ifOut && !ifRdy))) begin
        busy = 1'b1;
        grantAt = k;
        if (dmOut && !dmRdy) begin
          owner = REQ_D; ownStore = busA.dm_we; ownAddr = busA.dm_addr; ownWdata = busA.dm_wdata;
          if (ownStore) refMem[ownAddr] = ownWdata;
          else result = refMem[ownAddr];
        end else begin
          owner = REQ_I; ownStore = 1'b0; ownAddr = busA.if_addr;
          result = refMem[ownAddr];
        end
      end
      if (ifRdy) ifOut = 1'b0;
      if (dmRdy) dmOut = 1'b0;
    end
    nextCycle();
    idleInputs();
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store_load();
    test_reset_mid();
    test_held_req();
    test_lat1();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
